// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver
//   Time-multiplexes a 4-digit packed hex/BCD value onto a common-anode
//   4-digit 7-segment module. Segments and commons are active-low.
//   value/dp are captured into a shadow register once per frame, so a frame
//   is always drawn from a consistent snapshot. At the start of every digit
//   slot there is a short all-off guard that stops ghosting between digits.
//
// Parameters
//   SCAN_DIV     clk cycles per digit slot; must be > BLANK_GUARD+1
//   BLANK_GUARD  all-off cycles at the start of each slot (0 = no guard)
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   value[15:0] in   digit3..digit0 = value[15:12]..value[3:0]
//   dp[3:0]     in   dp[i]=1 lights the decimal point of digit i
//   seg_7[7:0]  out  active-low {dp,g,f,e,d,c,b,a}
//   com[3:0]    out  active-low digit enables, com[0] = rightmost digit
//   frame_tick  out  one-cycle pulse the cycle after a shadow load
//
// Build option
//   FND_ZERO_BLANK_EN  leading-zero suppression on digits 3..1; digit 0 is
//                      never blanked and a blanked digit keeps its dp.

module fnd_scan_driver #(
   parameter int SCAN_DIV    = 100000,
   parameter int BLANK_GUARD = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] value,
   input  logic [3:0]  dp,
   output logic [7:0]  seg_7,
   output logic [3:0]  com,
   output logic        frame_tick
);

   localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [DW-1:0] div_q, div_d;
   logic [1:0]    idx_q, idx_d;
   logic          first_q;
   logic [15:0]   val_q, val_d;
   logic [3:0]    dp_q, dp_d;
   logic          ft_q, ft_d;
   logic [7:0]    seg_q, seg_d;
   logic [3:0]    com_q, com_d;

   logic          tick, load, guard, blank;
   logic [15:0]   src_val;
   logic [3:0]    src_dp;
   logic [3:0]    nib;
   logic [6:0]    glyph;

   // Active-low g..a patterns.
   function automatic logic [6:0] seg_lut(input logic [3:0] n);
      logic [6:0] g;
      g = 7'h7F;
      case (n)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         4'hF: g = 7'h0E;
         default: g = 7'h7F;
      endcase
      return g;
   endfunction

   assign tick = (div_q == DW'(SCAN_DIV - 1));
   // First edge after reset loads the shadow; afterwards once per frame as
   // the digit index wraps 3 -> 0.
   assign load = first_q | (tick & (idx_q == 2'd3));

   // On the very first edge the shadow is still being loaded, so draw from
   // the inputs directly; this matters only when BLANK_GUARD is 0.
   assign src_val = first_q ? value : val_q;
   assign src_dp  = first_q ? dp    : dp_q;

   assign guard = (BLANK_GUARD > 0) && (int'(div_q) < BLANK_GUARD);
   assign nib   = src_val[{idx_q, 2'b00} +: 4];

`ifdef FND_ZERO_BLANK_EN
   // Blank when this digit and everything to its left is zero.
   assign blank = (idx_q != 2'd0) && ((src_val >> {idx_q, 2'b00}) == 16'h0);
`else
   assign blank = 1'b0;
`endif

   assign glyph = blank ? 7'h7F : seg_lut(nib);

   always_comb begin
      div_d = tick ? '0 : div_q + 1'b1;
      idx_d = tick ? idx_q + 2'd1 : idx_q;
      val_d = load ? value : val_q;
      dp_d  = load ? dp    : dp_q;
      ft_d  = load;
      seg_d = 8'hFF;
      com_d = 4'hF;
      if (!guard) begin
         seg_d = {~src_dp[idx_q], glyph};
         com_d = ~(4'b0001 << idx_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q   <= '0;
         idx_q   <= 2'd0;
         first_q <= 1'b1;
         val_q   <= 16'h0;
         dp_q    <= 4'h0;
         ft_q    <= 1'b0;
         seg_q   <= 8'hFF;
         com_q   <= 4'hF;
      end else begin
         div_q   <= div_d;
         idx_q   <= idx_d;
         first_q <= 1'b0;
         val_q   <= val_d;
         dp_q    <= dp_d;
         ft_q    <= ft_d;
         seg_q   <= seg_d;
         com_q   <= com_d;
      end
   end

   assign seg_7      = seg_q;
   assign com        = com_q;
   assign frame_tick = ft_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Scoreboard bench for fnd_scan_driver. Two instances share stimulus: one
// with a 2-cycle guard, one with no guard. The reference model derives the
// expected pins from the cycle number since reset release and the frame
// snapshot of value/dp.
module tb_fnd_scan_driver;
   localparam int SD = 8;
   localparam int G0 = 2;
   localparam int FR = 4 * SD;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] value = 16'h0;
   logic [3:0]  dp = 4'h0;
   logic [7:0]  seg0, seg1;
   logic [3:0]  com0, com1;
   logic        ft0, ft1;

   always #5 clk = ~clk;

   fnd_scan_driver #(.SCAN_DIV(SD), .BLANK_GUARD(G0)) u_g2 (
      .clk(clk), .reset_n(reset_n), .value(value), .dp(dp),
      .seg_7(seg0), .com(com0), .frame_tick(ft0));

   fnd_scan_driver #(.SCAN_DIV(SD), .BLANK_GUARD(0)) u_g0 (
      .clk(clk), .reset_n(reset_n), .value(value), .dp(dp),
      .seg_7(seg1), .com(com1), .frame_tick(ft1));

   typedef struct {
      int         k;
      logic [3:0] com0;
      logic [7:0] seg0;
      logic [3:0] com1;
      logic [7:0] seg1;
      logic       ft;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;
   int k = 0;
   logic [15:0] fv;
   logic [3:0]  fd;

   logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s k=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   // Expected pins after the k-th rising edge since release.
   function automatic exp_t model(input int kk, input logic [15:0] v, input logic [3:0] d);
      exp_t e;
      int div, idx, upper;
      logic [7:0] s;
      logic [3:0] c;
      div   = kk % SD;
      idx   = (kk / SD) % 4;
      upper = int'(v) >> (4 * idx);
      c = 4'hF;
      c[idx] = 1'b0;
      s = tbl[upper & 15];
      s[7] = ~d[idx];
`ifdef FND_ZERO_BLANK_EN
      if (idx > 0 && upper == 0) s[6:0] = 7'h7F;
`endif
      e.k    = kk;
      e.ft   = (kk == 0) || (kk % FR == FR - 1);
      e.com1 = c;
      e.seg1 = s;
      e.com0 = (div < G0) ? 4'hF : c;
      e.seg0 = (div < G0) ? 8'hFF : s;
      return e;
   endfunction

   // Called at negedge+1; leaves at negedge+1.
   task automatic run(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         if (rnd && $urandom_range(15) == 0) begin
            value = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            dp    = 4'($urandom_range(0, 15));
         end
         if (k == 0) begin fv = value; fd = dp; end
         q.push_back(model(k, fv, fd));
         if (k % FR == FR - 1) begin fv = value; fd = dp; end
         k++;
         @(negedge clk); #1;
      end
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_com0"}, k, 32'(com0), 32'hF);
      chk({nm, "_seg0"}, k, 32'(seg0), 32'hFF);
      chk({nm, "_ft0"},  k, 32'(ft0),  32'h0);
      chk({nm, "_com1"}, k, 32'(com1), 32'hF);
      chk({nm, "_seg1"}, k, 32'(seg1), 32'hFF);
      chk({nm, "_ft1"},  k, 32'(ft1),  32'h0);
   endtask

   // Monitor: outputs are live every cycle, compare at the falling edge.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("com_g2", e.k, 32'(com0), 32'(e.com0));
         chk("seg_g2", e.k, 32'(seg0), 32'(e.seg0));
         chk("tick_g2", e.k, 32'(ft0), 32'(e.ft));
         chk("com_g0", e.k, 32'(com1), 32'(e.com1));
         chk("seg_g0", e.k, 32'(seg1), 32'(e.seg1));
         chk("tick_g0", e.k, 32'(ft1), 32'(e.ft));
      end
   end

   initial begin
      value = 16'h1234;
      dp    = 4'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_reset("rst");
      end
      #1 reset_n = 1'b1;
      k = 0;
      // Mid-frame change while index 1 is on display.
      run(42, 1'b0);
      value = 16'h5678;
      run(62, 1'b0);
      value = 16'h0008; dp = 4'b0100; run(64, 1'b0);
      value = 16'h0007; dp = 4'b0000; run(64, 1'b0);
      value = 16'h0000; dp = 4'b1010; run(64, 1'b0);
      value = 16'h0100; dp = 4'b0001; run(64, 1'b0);
      value = 16'hABCD; dp = 4'b1111; run(64, 1'b0);
      value = 16'hEF90; dp = 4'b0000; run(64, 1'b0);
      run(1200, 1'b1);
      // Asynchronous reset in the middle of a slot.
      run(13, 1'b1);
      #2 reset_n = 1'b0;
      #1 chk_reset("async_rst");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_reset("rst_hold");
      end
      #1 reset_n = 1'b1;
      k = 0;
      run(300, 1'b1);
      @(negedge clk); #1;
      chk("queue_drained", k, 32'(q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
